// File: rtl/spi_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : spi_peripheral
// Description : Oversampled SPI target, all four CPOL/CPHA modes, MSB first,
//               with a one-deep transmit holding register and rx strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_peripheral #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy,
    input  logic                  si,
    output logic                  so,
    output logic                  so_highz,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  phase,
    input  logic                  polarity
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_si_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    logic                   r_pha;
    logic                   r_pol;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_WIDTH-1:0]  r_rx_shift;
    logic [DATA_WIDTH-1:0]  r_tx_shift;
    logic [DATA_WIDTH-1:0]  r_rx_data;
    logic                   r_rx_valid;
    logic                   r_underrun;
    logic [DATA_WIDTH-1:0]  r_hold;
    logic                   r_hold_valid;

    logic                   w_sck;
    logic                   w_cs;
    logic                   w_si;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_sample_edge;
    logic                   w_shift_edge;
    logic                   w_enter;
    logic                   w_exit;
    logic                   w_sample;
    logic                   w_shift;
    logic                   w_load;
    logic                   w_underrun;
    logic [DATA_WIDTH-1:0]  w_load_data;
    logic [DATA_WIDTH-1:0]  w_rx_next;

    // Synchronizers plus one delay flop on sck/cs_n for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync <= '0;
            r_cs_sync  <= '1;
            r_si_sync  <= '0;
            r_sck_d    <= 1'b0;
            r_cs_d     <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_si_sync  <= {r_si_sync[SYNC_STAGES-2:0], si};
            r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
            r_cs_d     <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sck     = r_sck_sync[SYNC_STAGES-1];
    assign w_cs      = r_cs_sync[SYNC_STAGES-1];
    assign w_si      = r_si_sync[SYNC_STAGES-1];
    assign w_cs_fall = r_cs_d & ~w_cs;
    assign w_cs_rise = ~r_cs_d & w_cs;

    // Leading edge leaves the idle level, trailing edge returns to it.
    assign w_lead        = (r_sck_d == r_pol) && (w_sck != r_pol);
    assign w_trail       = (r_sck_d != r_pol) && (w_sck == r_pol);
    assign w_sample_edge = r_pha ? w_trail : w_lead;
    assign w_shift_edge  = r_pha ? w_lead  : w_trail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // cs_n rising beats any sck edge seen in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_enter      = 1'b0;
        w_exit       = 1'b0;
        w_sample     = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_ACTIVE;
                    w_enter      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                    w_exit       = 1'b1;
                end else begin
                    w_sample = w_sample_edge;
                    w_shift  = w_shift_edge;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // An empty holding register bypasses a same-cycle tx_data, else sends zero.
    assign w_load      = (w_enter && !phase) || (w_shift && (r_cnt == '0));
    assign w_load_data = r_hold_valid ? r_hold :
                         (tx_valid ? tx_data : '0);
    assign w_underrun  = w_load && !r_hold_valid && !tx_valid;
    assign w_rx_next   = {r_rx_shift[DATA_WIDTH-2:0], w_si};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_load) begin
            r_hold_valid <= 1'b0;
        end else if (tx_valid && !r_hold_valid) begin
            r_hold       <= tx_data;
            r_hold_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pha      <= 1'b0;
            r_pol      <= 1'b0;
            r_cnt      <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= w_underrun;
            if (w_enter) begin
                r_pha      <= phase;
                r_pol      <= polarity;
                r_cnt      <= '0;
                r_rx_shift <= '0;
                r_tx_shift <= phase ? '0 : w_load_data;
            end else if (w_exit) begin
                r_cnt      <= '0;
                r_tx_shift <= '0;
            end else begin
                if (w_sample) begin
                    r_rx_shift <= w_rx_next;
                    r_cnt      <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_rx_data  <= w_rx_next;
                        r_rx_valid <= 1'b1;
                    end
                end
                if (w_shift) begin
                    r_tx_shift <= (r_cnt == '0) ? w_load_data :
                                  {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign tx_ready    = ~r_hold_valid;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_underrun;
    assign busy        = (r_state == ST_ACTIVE);
    assign so          = r_tx_shift[DATA_WIDTH-1];
    assign so_highz    = ~busy;

endmodule
`default_nettype wire
